// File: rtl/sfx_pkg.sv
// -----------------------------------------------------------------------------
// sfx_pkg
// Shared definitions for the sound-effect sequencer:
//   - note codes and their frequencies (Hz) used to build note dividers
//   - MUTE_DIV, the divider value driven while silent
//   - jingle identifiers (SFX_BEEP, SFX_GO, SFX_FINISH, SFX_PAUSE)
//   - FSM state encoding
//   - ROM word layout {last, note, dur} and field widths
// -----------------------------------------------------------------------------
package sfx_pkg;

    localparam int ID_W   = 2;
    localparam int STEP_W = 3;
    localparam int NOTE_W = 4;
    localparam int DUR_W  = 6;
    localparam int DIV_W  = 22;
    localparam int VOL_W  = 3;

    localparam logic [DIV_W-1:0] MUTE_DIV = 22'h3FFFFF;

    // Note codes: 0 rest, 1..7 C4..B4, 8..14 C5..B5, 15 reserved (rest)
    localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_D4   = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_E4   = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_F4   = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_G4   = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_A4   = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_B4   = 4'd7;
    localparam logic [NOTE_W-1:0] NOTE_C5   = 4'd8;
    localparam logic [NOTE_W-1:0] NOTE_D5   = 4'd9;
    localparam logic [NOTE_W-1:0] NOTE_E5   = 4'd10;
    localparam logic [NOTE_W-1:0] NOTE_F5   = 4'd11;
    localparam logic [NOTE_W-1:0] NOTE_G5   = 4'd12;
    localparam logic [NOTE_W-1:0] NOTE_A5   = 4'd13;
    localparam logic [NOTE_W-1:0] NOTE_B5   = 4'd14;
    localparam logic [NOTE_W-1:0] NOTE_RSVD = 4'd15;

    // Frequency per note code; 0 marks a silent code
    localparam int unsigned NOTE_HZ [16] = '{
        0,
        262, 294, 330, 349, 392, 440, 494,
        524, 588, 660, 698, 784, 880, 988,
        0
    };

    localparam logic [ID_W-1:0] SFX_BEEP   = 2'd0;
    localparam logic [ID_W-1:0] SFX_GO     = 2'd1;
    localparam logic [ID_W-1:0] SFX_FINISH = 2'd2;
    localparam logic [ID_W-1:0] SFX_PAUSE  = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    typedef struct packed {
        logic              last;
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } sfx_word_t;

    function automatic sfx_word_t mk_word(input logic last,
                                          input logic [NOTE_W-1:0] note,
                                          input logic [DUR_W-1:0] dur);
        sfx_word_t w;
        w.last = last;
        w.note = note;
        w.dur  = dur;
        return w;
    endfunction

    function automatic logic note_is_rest(input logic [NOTE_W-1:0] note);
        return (note == NOTE_REST) || (note == NOTE_RSVD);
    endfunction

endpackage

// File: rtl/sfx_rom.sv
// -----------------------------------------------------------------------------
// sfx_rom
// Combinational jingle ROM plus note-to-divider decode.
// Ports:
//   sfx_id  in  2   jingle select
//   step    in  3   step index within the jingle
//   last    out 1   this step ends the jingle
//   dur     out 6   step duration in ticks (raw; 0 is handled by the caller)
//   div     out 22  half-period divider for the step's note (MUTE_DIV on rest)
//   silent  out 1   step is a rest (volume must be 0)
// Parameters:
//   CLK_HZ  system clock used to derive dividers at elaboration
// -----------------------------------------------------------------------------
module sfx_rom
    import sfx_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic [ID_W-1:0]   sfx_id,
    input  logic [STEP_W-1:0] step,
    output logic              last,
    output logic [DUR_W-1:0]  dur,
    output logic [DIV_W-1:0]  div,
    output logic              silent
);

    function automatic logic [DIV_W-1:0] calc_div(input int unsigned hz);
        if (hz == 0) begin
            return MUTE_DIV;
        end
        return DIV_W'(CLK_HZ / (2 * hz));
    endfunction

    // Divider table is fully constant; synthesis folds it into a small mux.
    logic [DIV_W-1:0] div_lut [16];

    for (genvar g = 0; g < 16; g++) begin : g_div_lut
        assign div_lut[g] = calc_div(NOTE_HZ[g]);
    end

    sfx_word_t word;

    always_comb begin
        word = mk_word(1'b0, NOTE_REST, 6'd0);
        case ({sfx_id, step})
            {SFX_BEEP,   3'd0}: word = mk_word(1'b1, NOTE_A4,   6'd15);
            {SFX_GO,     3'd0}: word = mk_word(1'b1, NOTE_A5,   6'd60);
            {SFX_FINISH, 3'd0}: word = mk_word(1'b0, NOTE_C5,   6'd12);
            {SFX_FINISH, 3'd1}: word = mk_word(1'b0, NOTE_E5,   6'd12);
            {SFX_FINISH, 3'd2}: word = mk_word(1'b0, NOTE_G5,   6'd12);
            {SFX_FINISH, 3'd3}: word = mk_word(1'b0, NOTE_REST, 6'd6);
            {SFX_FINISH, 3'd4}: word = mk_word(1'b0, NOTE_E5,   6'd12);
            {SFX_FINISH, 3'd5}: word = mk_word(1'b1, NOTE_G5,   6'd40);
            {SFX_PAUSE,  3'd0}: word = mk_word(1'b0, NOTE_G4,   6'd20);
            {SFX_PAUSE,  3'd1}: word = mk_word(1'b1, NOTE_D4,   6'd20);
            default:            word = mk_word(1'b0, NOTE_REST, 6'd0);
        endcase
    end

    assign last   = word.last;
    assign dur    = word.dur;
    assign div    = div_lut[word.note];
    assign silent = note_is_rest(word.note);

endmodule

// File: rtl/sfx_sequencer.sv
// -----------------------------------------------------------------------------
// sfx_sequencer
// ROM-driven sound-effect player feeding the note generator. A one-cycle trig
// starts (or restarts) one of four jingles; each step holds a note for
// dur*TICK_CYCLES clocks, and the jingle ends with a one-cycle done pulse.
// Ports:
//   clk       in  1   system clock
//   rst       in  1   synchronous active-high reset
//   trig      in  1   one-cycle start pulse (preempts a playing jingle)
//   sfx_id    in  2   jingle select, sampled with trig
//   note_div  out 22  half-period divider, MUTE_DIV when silent
//   volume    out 3   volume code, 0 when silent
//   busy      out 1   high while a jingle plays
//   done      out 1   one-cycle pulse on normal completion
// Parameters: CLK_HZ, TICK_CYCLES, VOLUME, GAP_TICKS (1..63)
// Build option: define SFX_GAP_EN to insert GAP_TICKS muted ticks between
// consecutive steps; without it steps play back-to-back.
// -----------------------------------------------------------------------------
module sfx_sequencer
    import sfx_pkg::*;
#(
    parameter int unsigned      CLK_HZ      = 100_000_000,
    parameter int unsigned      TICK_CYCLES = 1_000_000,
    parameter logic [VOL_W-1:0] VOLUME      = 3'd4,
    parameter int unsigned      GAP_TICKS   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic [ID_W-1:0]   sfx_id,
    output logic [DIV_W-1:0]  note_div,
    output logic [VOL_W-1:0]  volume,
    output logic              busy,
    output logic              done
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [DUR_W-1:0] GAP_LOAD  = (GAP_TICKS == 0) ? 6'd1 : DUR_W'(GAP_TICKS);

    logic [1:0]        state;
    logic [ID_W-1:0]   cur_id;
    logic [STEP_W-1:0] step;
    logic [TW-1:0]     tick_cnt;
    logic [DUR_W-1:0]  dur_cnt;   // ticks remaining in the current step or gap
    logic              cur_last;  // latched at step start so step end needs no second lookup

    logic [1:0]        next_state;
    logic [ID_W-1:0]   next_id;
    logic [STEP_W-1:0] next_step;
    logic              start_step;
    logic              start_gap;
    logic              finish;
    logic              tick_wrap;
    logic              seg_end;

    logic              rom_last;
    logic [DUR_W-1:0]  rom_dur;
    logic [DIV_W-1:0]  rom_div;
    logic              rom_silent;

    // The ROM is addressed with the step about to start, so the registered
    // outputs already show the new note on the edge the step begins.
    sfx_rom #(
        .CLK_HZ (CLK_HZ)
    ) u_rom (
        .sfx_id (next_id),
        .step   (next_step),
        .last   (rom_last),
        .dur    (rom_dur),
        .div    (rom_div),
        .silent (rom_silent)
    );

    assign tick_wrap = (tick_cnt == TICK_LAST);
    assign seg_end   = (state != ST_IDLE) && tick_wrap && (dur_cnt <= 6'd1);

    always_comb begin
        next_state = state;
        next_id    = cur_id;
        next_step  = step;
        start_step = 1'b0;
        start_gap  = 1'b0;
        finish     = 1'b0;
        if (trig) begin
            // Any trig restarts from step 0, even on a step or final edge.
            next_state = ST_PLAY;
            next_id    = sfx_id;
            next_step  = '0;
            start_step = 1'b1;
        end else if (seg_end) begin
            if (state == ST_GAP) begin
                next_state = ST_PLAY;
                start_step = 1'b1;
            end else if (cur_last) begin
                next_state = ST_IDLE;
                finish     = 1'b1;
            end else begin
                next_step = step + 3'd1;
`ifdef SFX_GAP_EN
                next_state = ST_GAP;
                start_gap  = 1'b1;
`else
                next_state = ST_PLAY;
                start_step = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cur_id   <= '0;
            step     <= '0;
            tick_cnt <= '0;
            dur_cnt  <= '0;
            cur_last <= 1'b0;
            note_div <= MUTE_DIV;
            volume   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state  <= next_state;
            cur_id <= next_id;
            step   <= next_step;
            busy   <= (next_state != ST_IDLE);
            done   <= finish;
            if (start_step) begin
                tick_cnt <= '0;
                dur_cnt  <= (rom_dur == 6'd0) ? 6'd1 : rom_dur;
                // Step 7 is the final slot; it ends the jingle regardless of the flag.
                cur_last <= rom_last || (next_step == 3'd7);
                note_div <= rom_silent ? MUTE_DIV : rom_div;
                volume   <= rom_silent ? 3'd0 : VOLUME;
            end else if (start_gap) begin
                tick_cnt <= '0;
                dur_cnt  <= GAP_LOAD;
                note_div <= MUTE_DIV;
                volume   <= '0;
            end else if (finish) begin
                tick_cnt <= '0;
                dur_cnt  <= '0;
                note_div <= MUTE_DIV;
                volume   <= '0;
            end else if (state != ST_IDLE) begin
                if (tick_wrap) begin
                    tick_cnt <= '0;
                    dur_cnt  <= dur_cnt - 6'd1;
                end else begin
                    tick_cnt <= tick_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sfx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sfx_sequencer
// Scoreboard bench for sfx_sequencer with TICK_CYCLES=10. Each driven cycle
// pushes the outputs expected after the coming edge; a monitor pops and
// compares them just after that edge. Expected waveforms come from the
// jingle note/duration tables written out here in Hz-derived dividers.
// -----------------------------------------------------------------------------
module tb_sfx_sequencer;

    localparam logic [21:0] MUTE = 22'h3FFFFF;
`ifdef SFX_GAP_EN
    localparam int GAP_CYC = 20;
`else
    localparam int GAP_CYC = 0;
`endif

    typedef struct packed {
        logic [21:0] div;
        logic [2:0]  vol;
        logic        busy;
        logic        done;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trig = 1'b0;
    logic [1:0]  sfx_id = 2'd0;
    logic [21:0] note_div;
    logic [2:0]  volume;
    logic        busy;
    logic        done;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    out_t exp_q[$];
    out_t wave_q[$];

    sfx_sequencer #(
        .CLK_HZ      (100_000_000),
        .TICK_CYCLES (10),
        .VOLUME      (3'd4),
        .GAP_TICKS   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .trig     (trig),
        .sfx_id   (sfx_id),
        .note_div (note_div),
        .volume   (volume),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic out_t mk_out(input logic [21:0] d, input logic [2:0] v,
                                    input logic b, input logic dn);
        out_t o;
        o.div = d; o.vol = v; o.busy = b; o.done = dn;
        return o;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Expand a jingle into its per-cycle expected outputs.
    task automatic load_jingle(input logic [1:0] id);
        int unsigned d[$];
        int unsigned l[$];
        wave_q.delete();
        case (id)
            2'd0: begin d = '{113636}; l = '{150}; end
            2'd1: begin d = '{56818};  l = '{600}; end
            2'd2: begin
                d = '{95419, 75757, 63775, 22'h3FFFFF, 75757, 63775};
                l = '{120, 120, 120, 60, 120, 400};
            end
            default: begin d = '{127551, 170068}; l = '{200, 200}; end
        endcase
        for (int s = 0; s < d.size(); s++) begin
            if (s > 0) begin
                repeat (GAP_CYC) wave_q.push_back(mk_out(MUTE, 3'd0, 1'b1, 1'b0));
            end
            repeat (l[s]) begin
                wave_q.push_back(mk_out(22'(d[s]), (d[s] == MUTE) ? 3'd0 : 3'd4, 1'b1, 1'b0));
            end
        end
        wave_q.push_back(mk_out(MUTE, 3'd0, 1'b0, 1'b1));
    endtask

    task automatic drive(input logic r, input logic t, input logic [1:0] id);
        out_t e;
        @(negedge clk);
        rst    = r;
        trig   = t;
        sfx_id = id;
        if (r) begin
            wave_q.delete();
            e = mk_out(MUTE, 3'd0, 1'b0, 1'b0);
        end else begin
            if (t) load_jingle(id);
            if (wave_q.size() > 0) e = wave_q.pop_front();
            else                   e = mk_out(MUTE, 3'd0, 1'b0, 1'b0);
        end
        exp_q.push_back(e);
    endtask

    // sfx_id wanders while idle/busy to show it is only sampled with trig.
    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 2'($urandom));
    endtask

    initial begin : monitor
        out_t e;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("note_div", 32'(note_div), 32'(e.div));
                check_eq("volume",   32'(volume),   32'(e.vol));
                check_eq("busy",     32'(busy),     32'(e.busy));
                check_eq("done",     32'(done),     32'(e.done));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // Reset then long idle
        repeat (3) drive(1'b1, 1'b0, 2'd0);
        idle(1000);
        // BEEP
        drive(1'b0, 1'b1, 2'd0);
        idle(170);
        // FINISH full sequence
        drive(1'b0, 1'b1, 2'd2);
        idle(1200);
        // Preempt FINISH with GO 50 clocks in
        drive(1'b0, 1'b1, 2'd2);
        idle(49);
        drive(1'b0, 1'b1, 2'd1);
        idle(650);
        // trig together with rst: stays idle
        drive(1'b1, 1'b1, 2'd1);
        idle(10);
        // rst mid-jingle
        drive(1'b0, 1'b1, 2'd3);
        idle(100);
        drive(1'b1, 1'b0, 2'd0);
        idle(20);
        // trig on the final step edge of BEEP: GO wins, no done
        drive(1'b0, 1'b1, 2'd0);
        idle(149);
        drive(1'b0, 1'b1, 2'd1);
        idle(650);
        // PAUSE (gap behaviour depends on build)
        drive(1'b0, 1'b1, 2'd3);
        idle(480);
        // Same-id restart
        drive(1'b0, 1'b1, 2'd0);
        idle(69);
        drive(1'b0, 1'b1, 2'd0);
        idle(170);
        // Let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #5;
        if (exp_q.size() != 0) check_eq("drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
